bcd_time_display: RTL

Scans the 24-bit packed-BCD time word (hh:mm:ss, six digits) produced by the hour counter onto a six-digit, common-anode, multiplexed seven-segment display. The block snapshots the time word once per scan frame to avoid tearing. It decodes one digit at a time, drives active-low anode and segment lines, and blinks the separator decimal points. It sits directly downstream of the hour counter, between it and the board's display pins.

---
 rtl/bcd_time_display.sv | 83 ++++++++
 1 files changed

// File: rtl/bcd_time_display.sv
// bcd_time_display: scans a packed-BCD hh:mm:ss word onto a six-digit multiplexed 7-segment display.
// Ports: CLK clock; reset active-low sync; data packed BCD time (hour tens at [23:20] .. second units at [3:0]);
//        en scan enable (0 blanks and freezes); blank_lz blank a zero hour-tens digit;
//        an active-low anodes (0 = second units); seg active-low {g..a}; dp active-low decimal point;
//        frame_done one-cycle pulse at each frame wrap.
module bcd_time_display #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [23:0] data,
   input  logic        en,
   input  logic        blank_lz,
   output logic [5:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);
   localparam int TW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [TW-1:0] tick;
   logic [BW-1:0] blink;
   logic [2:0]    idx;
   logic [23:0]   snap;
   logic          first, phase;
   logic [3:0]    nib;
   logic [6:0]    seg_d;
   logic          tick_end, wrap, blink_end, lz;
   always_comb begin
      nib = snap[{idx, 2'b00} +: 4];
      case (nib)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;
      endcase
      tick_end  = tick == TW'(REFRESH_DIV - 1);
      wrap      = tick_end && idx == 3'd5;
      blink_end = blink == BW'(BLINK_FRAMES - 1);
      lz        = blank_lz && idx == 3'd5 && snap[23:20] == 4'd0;
   end
   always_ff @(posedge CLK) begin
      if (!reset) begin
         tick       <= '0;
         idx        <= '0;
         snap       <= '0;
         first      <= 1'b1;
         blink      <= '0;
         phase      <= 1'b1;
         an         <= '1;
         seg        <= '1;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else if (en) begin
         tick  <= tick_end ? '0 : tick + 1'b1;
         if (tick_end) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
         // first enabled edge after reset fills the snapshot so the first frame is not all zeros
         if (first || wrap) snap <= data;
         first <= 1'b0;
         if (wrap) begin
            blink <= blink_end ? '0 : blink + 1'b1;
            if (blink_end) phase <= ~phase;
         end
         an         <= lz ? '1 : ~(6'b1 << idx);
         seg        <= lz ? '1 : seg_d;
         dp         <= !(phase && (idx == 3'd2 || idx == 3'd4));
         frame_done <= wrap;
      end else begin
         an         <= '1;
         seg        <= '1;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end
   end
endmodule
